// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack between two requesters.
// It sequences each push/pop, tracks occupancy and returns ack/err/rdata to the winner.
module stack_arbiter #(
  parameter int DW    = 2,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          op0,
  input  logic [DW-1:0] wd0,
  input  logic          req1,
  input  logic          op1,
  input  logic [DW-1:0] wd1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_in,
  input  logic [DW-1:0] stk_out,
  input  logic          stk_empty,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          busy
);

  // state | meaning
  // IDLE  | sample requests, grant round-robin, latch id/op/data
  // EXEC  | drive one push or pop strobe, or flag a reject
  // WAIT  | stack has registered pop data; capture it into rdata
  // RESP  | one-cycle ack to the granted requester, err = reject flag
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          op_q, op_d;
  logic          rej_q, rej_d;
  logic          grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    wd_d     = wd_q;
    last_d   = last_q;
    id_d     = id_q;
    op_d     = op_q;
    rej_d    = rej_q;
    grant    = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_in   = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // With both requesting, the one that did not win last time goes first.
          grant   = (req0 && req1) ? ~last_q : req1;
          id_d    = grant;
          op_d    = grant ? op1 : op0;
          wd_d    = grant ? wd1 : wd0;
          last_d  = grant;
          rej_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!op_q) begin
          if (count_q < DEPTH_C) begin
            stk_push = 1'b1;
            stk_in   = wd_q;
            count_d  = count_q + ONE_C;
            rej_d    = 1'b0;
          end else begin
            rej_d = 1'b1;
          end
          state_d = RESP;
        end else if ((count_q != '0) && !stk_empty) begin
          stk_pop = 1'b1;
          count_d = count_q - ONE_C;
          rej_d   = 1'b0;
          state_d = WAIT;
        end else begin
          rej_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        rdata_d = stk_out;
        state_d = RESP;
      end
      RESP: begin
        ack0    = ~id_q;
        ack1    = id_q;
        err     = rej_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural 256x2 LIFO as the shared resource,
// a reference LIFO feeding a scoreboard of expected acks, and scenario tasks.
module tb_stack_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, op0, req1, op1;
  logic [1:0] wd0, wd1;
  logic       ack0, ack1, err;
  logic [1:0] rdata;
  logic       stk_push, stk_pop;
  logic [1:0] stk_in;
  logic [1:0] stk_out;
  logic       stk_empty;
  logic [8:0] count;
  logic       full, busy;

  int errors = 0;
  int checks = 0;

  stack_arbiter #(.DW(2), .DEPTH(256), .CW(9)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .wd0(wd0),
    .req1(req1), .op1(op1), .wd1(wd1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in),
    .stk_out(stk_out), .stk_empty(stk_empty),
    .count(count), .full(full), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack resource: active-high reset from ~rst, read data registered on the pop edge.
  logic [1:0] mem [0:255];
  logic [8:0] sp;
  logic       stk_rst;
  assign stk_rst   = ~rst;
  assign stk_empty = (sp == 9'd0);

  always @(posedge clk or posedge stk_rst) begin
    if (stk_rst) begin
      sp      <= 9'd0;
      stk_out <= 2'b00;
    end else if (stk_push) begin
      mem[sp[7:0]] <= stk_in;
      sp           <= sp + 9'd1;
    end else if (stk_pop) begin
      stk_out <= mem[sp[7:0] - 8'd1];
      sp      <= sp - 9'd1;
    end
  end

  typedef struct {
    int         id;
    logic       err;
    logic [1:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] ref_q[$];
  int         ref_last;
  logic [1:0] exp_rdata;

  function automatic void model_reset();
    sb.delete();
    ref_q.delete();
    ref_last  = 1;
    exp_rdata = 2'b00;
  endfunction

  function automatic void predict(input int id, input logic op, input logic [1:0] wd);
    exp_t e;
    e.id     = id;
    ref_last = id;
    if (!op) begin
      if (ref_q.size() < 256) begin
        ref_q.push_back(wd);
        e.err = 1'b0;
      end else begin
        e.err = 1'b1;
      end
    end else begin
      if (ref_q.size() != 0) begin
        exp_rdata = ref_q.pop_back();
        e.err     = 1'b0;
      end else begin
        e.err = 1'b1;
      end
    end
    e.rdata = exp_rdata;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor and per-cycle strobe rules.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (stk_push && stk_pop) begin
        errors++;
        $display("FAIL strobe_overlap push=%0b pop=%0b expected not both", stk_push, stk_pop);
      end
      checks++;
      if (!stk_push && stk_in !== 2'b00) begin
        errors++;
        $display("FAIL stk_in_idle got=%b expected=00", stk_in);
      end
      if (ack0 || ack1) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack ack0=%0b ack1=%0b expected none", ack0, ack1);
        end else begin
          e = sb.pop_front();
          if (ack0 && ack1) begin
            errors++;
            $display("FAIL ack_both ack0=1 ack1=1 expected one-hot");
          end
          checks++;
          if ((ack1 ? 1 : 0) != e.id) begin
            errors++;
            $display("FAIL ack_id got=%0d expected=%0d", ack1 ? 1 : 0, e.id);
          end
          checks++;
          if (err !== e.err) begin
            errors++;
            $display("FAIL ack_err got=%0b expected=%0b", err, e.err);
          end
          checks++;
          if (rdata !== e.rdata) begin
            errors++;
            $display("FAIL ack_rdata got=%b expected=%b", rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rst  = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_op(input int id, input logic op, input logic [1:0] wd);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    predict(id, op, wd);
    if (id == 0) begin
      req0 = 1'b1; op0 = op; wd0 = wd;
    end else begin
      req1 = 1'b1; op1 = op; wd1 = wd;
    end
  endtask

  task automatic wait_ack(output int lat, output int npush, output int npop,
                          output logic [1:0] pdata, output int aid);
    lat = 0; npush = 0; npop = 0; pdata = 2'b00; aid = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      if (stk_push) begin
        npush++;
        pdata = stk_in;
      end
      if (stk_pop) npop++;
      if (ack0 || ack1) begin
        lat = i;
        aid = ack1 ? 1 : 0;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL ack_timeout got=no ack expected=ack within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0; wd0 = 2'b00; wd1 = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, full, ack0, ack1, err, stk_push, stk_pop} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0000000",
               {busy, full, ack0, ack1, err, stk_push, stk_pop});
    end
    checks++;
    if (count !== 9'd0 || rdata !== 2'b00) begin
      errors++;
      $display("FAIL reset_values count=%0d rdata=%b expected count=0 rdata=00", count, rdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push();
    int lat, np, npp, aid;
    logic [1:0] pd;
    start_op(0, 1'b0, 2'b10);
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL push_latency got=%0d expected=2", lat); end
    checks++;
    if (np != 1 || npp != 0 || pd !== 2'b10) begin
      errors++;
      $display("FAIL push_strobe push=%0d pop=%0d data=%b expected push=1 pop=0 data=10", np, npp, pd);
    end
    checks++;
    if (count !== 9'd1) begin errors++; $display("FAIL push_count got=%0d expected=1", count); end
    @(negedge clk);
  endtask

  task automatic test_pop();
    int lat, np, npp, aid;
    logic [1:0] pd;
    start_op(1, 1'b1, 2'b00);
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL pop_latency got=%0d expected=3", lat); end
    checks++;
    if (npp != 1 || np != 0) begin
      errors++;
      $display("FAIL pop_strobe pop=%0d push=%0d expected pop=1 push=0", npp, np);
    end
    checks++;
    if (rdata !== 2'b10 || count !== 9'd0) begin
      errors++;
      $display("FAIL pop_result rdata=%b count=%0d expected rdata=10 count=0", rdata, count);
    end
    @(negedge clk);
  endtask

  task automatic test_pop_empty();
    int lat, np, npp, aid;
    logic [1:0] pd;
    start_op(0, 1'b1, 2'b00);
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL pop_empty_latency got=%0d expected=2", lat); end
    checks++;
    if (npp != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty_reject pop=%0d err=%b expected pop=0 err=1", npp, err);
    end
    checks++;
    if (rdata !== 2'b10 || count !== 9'd0) begin
      errors++;
      $display("FAIL pop_empty_hold rdata=%b count=%0d expected rdata=10 count=0", rdata, count);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int ids[4];
    int n = 0;
    int g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      g = (ref_last == 0) ? 1 : 0;
      predict(g, 1'b0, (g == 1) ? 2'b11 : 2'b01);
    end
    req0 = 1'b1; op0 = 1'b0; wd0 = 2'b01;
    req1 = 1'b1; op1 = 1'b0; wd1 = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ids[n] = ack1 ? 1 : 0;
        n++;
        if (n == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_acks got=%0d expected=4", n); end
    checks++;
    if (ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1) begin
      errors++;
      $display("FAIL rr_order got=%0d%0d%0d%0d expected=0101", ids[0], ids[1], ids[2], ids[3]);
    end
    checks++;
    if (mem[0] !== 2'b01 || mem[1] !== 2'b11 || mem[2] !== 2'b01 || mem[3] !== 2'b11) begin
      errors++;
      $display("FAIL rr_contents got=%b %b %b %b expected=01 11 01 11", mem[0], mem[1], mem[2], mem[3]);
    end
    checks++;
    if (count !== 9'd4) begin errors++; $display("FAIL rr_count got=%0d expected=4", count); end
    @(negedge clk);
  endtask

  task automatic test_full();
    int lat, np, npp, aid;
    logic [1:0] pd;
    logic [1:0] d;
    while (ref_q.size() < 256) begin
      d = 2'($urandom_range(0, 3));
      start_op(0, 1'b0, d);
      wait_ack(lat, np, npp, pd, aid);
      @(negedge clk);
    end
    checks++;
    if (count !== 9'd256 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_reach count=%0d full=%b expected count=256 full=1", count, full);
    end
    start_op(1, 1'b0, 2'b01);
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (lat != 2 || np != 0) begin
      errors++;
      $display("FAIL full_reject latency=%0d push=%0d expected latency=2 push=0", lat, np);
    end
    checks++;
    if (count !== 9'd256) begin errors++; $display("FAIL full_hold got=%0d expected=256", count); end
    @(negedge clk);
    start_op(0, 1'b1, 2'b00);
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (lat != 3 || count !== 9'd255 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_pop latency=%0d count=%0d full=%b expected latency=3 count=255 full=0",
               lat, count, full);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, np, npp, aid;
    logic [1:0] pd;
    start_op(1, 1'b1, 2'b00);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (stk_pop !== 1'b1) begin errors++; $display("FAIL mid_exec_pop got=%b expected=1", stk_pop); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || stk_pop !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait busy=%b pop=%b expected busy=1 pop=0", busy, stk_pop);
    end
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || count !== 9'd0 || rdata !== 2'b00 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b count=%0d rdata=%b ack=%b%b expected busy=0 count=0 rdata=00 ack=00",
               busy, count, rdata, ack0, ack1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    predict(0, 1'b0, 2'b01);
    req0 = 1'b1; op0 = 1'b0; wd0 = 2'b01;
    req1 = 1'b1; op1 = 1'b0; wd1 = 2'b10;
    wait_ack(lat, np, npp, pd, aid);
    checks++;
    if (aid != 0 || lat != 2 || pd !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant id=%0d latency=%0d data=%b expected id=0 latency=2 data=01",
               aid, lat, pd);
    end
    checks++;
    if (count !== 9'd1) begin errors++; $display("FAIL post_reset_count got=%0d expected=1", count); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_pop_empty();
    test_round_robin();
    test_full();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack resource (256 entries × 2-bit, push/pop/empty interface) between two requesters.
- Arbitrates round-robin, sequences each push/pop through the stack, and tracks occupancy so full pushes are rejected instead of wrapping.
- Returns pop data and completion or error status to the winning requester.
- Sits between the requester logic and the stack instance.

Parameters:
- DW, 2, stack entry data width.
- DEPTH, 256, stack capacity in entries.
- CW, 9, occupancy counter width; must hold the value DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 operation request, level.
- op0  in  1  requester 0 opcode: 0 = push, 1 = pop.
- wd0  in  DW  requester 0 push data.
- req1  in  1  requester 1 operation request, level.
- op1  in  1  requester 1 opcode: 0 = push, 1 = pop.
- wd1  in  DW  requester 1 push data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- ack1  out  1  one-cycle completion pulse to requester 1.
- err  out  1  qualifies the current ack pulse as rejected.
- rdata  out  DW  pop result; valid while ack is high for a successful pop.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_in  out  DW  push data to the stack.
- stk_out  in  DW  stack read data, registered by the stack on the pop edge.
- stk_empty  in  1  stack empty flag.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst = 0, async) clears:
  - state to IDLE, count to 0, rdata to 0, last_grant to 1 (so requester 0 wins first);
  - latched op/data/id to 0;
  - ack0, ack1, err, stk_push, stk_pop and busy to 0.
- Integration: the stack instance uses an active-high reset and is driven from ~rst, so count and stack size clear together.
- FSM states are IDLE, EXEC, WAIT, RESP.
- IDLE:
  - reqX is sampled on each edge; if any is high, grant, latch id/op/wd, then go to EXEC.
  - If both are high, grant the requester not equal to last_grant. last_grant updates on grant.
- EXEC, push:
  - if count < DEPTH: stk_push = 1 for exactly this cycle, stk_in = latched data, count +1, go to RESP with err = 0;
  - otherwise: no strobe, go to RESP with err = 1.
- EXEC, pop:
  - if count != 0 and stk_empty = 0: stk_pop = 1 for exactly this cycle, count −1, go to WAIT;
  - otherwise: no strobe, go to RESP with err = 1.
- WAIT: capture stk_out into rdata, go to RESP.
- RESP:
  - ack of the latched id = 1 for one cycle; err holds the latched reject flag;
  - then go to IDLE.
- stk_in is 0 whenever stk_push = 0.
- stk_push and stk_pop are never high together.
- Latency, with req sampled at edge k:
  - push or rejected op: stk_push in cycle k+1, ack in cycle k+2;
  - successful pop: stk_pop in cycle k+1, ack plus rdata in cycle k+3.
- Throughput is one operation per 3 cycles (push/reject) or 4 cycles (pop), because RESP returns to IDLE before the next sample.
- Requesters drop req after ack. A req still held in IDLE is treated as a new request.
- rdata changes only on a successful pop and otherwise holds its last value.
- reqX, opX and wdX are ignored outside IDLE. Changing them mid-operation has no effect.
- Count saturates logically: it never exceeds DEPTH and never underflows, because rejects leave it unchanged.
- Reset asserted in any state aborts the operation: no ack is issued, and strobes drop immediately (async).

Test Plan:
- Reset, then req0 push wd0=2'b10 → stk_push high exactly one cycle with stk_in=10; ack0 2 cycles after sample, err=0; count=1.
- After the above, req1 pop → stk_pop one cycle; ack1 3 cycles after sample; rdata=2'b10, err=0; count=0.
- Pop with count=0 → no stk_pop; ack0 with err=1, 2 cycles after sample; rdata unchanged; count stays 0.
- req0 and req1 both held high, pushing wd0=01 and wd1=11 → grants alternate 0,1,0,1 starting with 0; stack contents in order 01,11,01,11; count=4.
- 256 pushes → full=1, count=256; 257th push gives ack with err=1, no stk_push, count stays 256; then pop returns the last pushed value.
- Drive rst low during WAIT → immediately state IDLE, busy=0, count=0, rdata=0, no ack; first request after release is granted to requester 0.
